// File: rtl/keypad_scanner.sv
// 4x3 keypad scan controller: rotates one-hot row drive, synchronises the columns,
// classifies each four-row frame, debounces single presses and hands keys out via ready/ack.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       col_x,
  input  logic       col_y,
  input  logic       col_z,
  output logic       row_a,
  output logic       row_b,
  output logic       row_c,
  output logic       row_d,
  output logic [3:0] key_value,
  output logic       key_ready,
  input  logic       key_ack,
  output logic       key_overrun
);

  localparam int              DW         = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_TARGET  = 4'(DEBOUNCE);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

  logic [2:0]    col_raw;
  logic [2:0]    col_meta_reg;
  logic [2:0]    col_sync_reg;
  logic [DW-1:0] dwell_reg;
  logic [1:0]    row_idx_reg;
  logic [3:0]    row_drive_reg;
  logic [1:0]    frame_cnt_reg;
  logic [3:0]    frame_code_reg;
  state_t        state_reg, state_next;
  logic [3:0]    match_cnt_reg, match_next;
  logic [3:0]    rel_cnt_reg, rel_next;
  logic [3:0]    cand_reg, cand_next;
  logic [3:0]    key_value_reg, key_value_next;
  logic          key_ready_reg, key_ready_next;
  logic          key_overrun_reg, key_overrun_next;

  assign col_raw = {col_z, col_y, col_x};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          col_meta_reg[gi] <= 1'b0;
          col_sync_reg[gi] <= 1'b0;
        end else begin
          col_meta_reg[gi] <= col_raw[gi];
          col_sync_reg[gi] <= col_meta_reg[gi];
        end
      end
    end
  endgenerate

  logic sample, frame_end;
  assign sample    = (dwell_reg == DWELL_LAST);
  assign frame_end = sample && (row_idx_reg == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg     <= '0;
      row_idx_reg   <= 2'd0;
      row_drive_reg <= 4'b0001;
    end else if (sample) begin
      dwell_reg     <= '0;
      row_idx_reg   <= row_idx_reg + 2'd1;
      row_drive_reg <= {row_drive_reg[2:0], row_drive_reg[3]};
    end else begin
      dwell_reg     <= dwell_reg + DW'(1);
    end
  end

  assign row_a = row_drive_reg[0];
  assign row_b = row_drive_reg[1];
  assign row_c = row_drive_reg[2];
  assign row_d = row_drive_reg[3];

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd7;
      4'b00_01: code = 4'd8;
      4'b00_10: code = 4'd9;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd1;
      4'b10_01: code = 4'd2;
      4'b10_10: code = 4'd3;
      4'b11_00: code = 4'd0;
      4'b11_01: code = 4'd15;
      4'b11_10: code = 4'd10;
      default:  code = 4'd0;
    endcase
    return code;
  endfunction

  // Frame intersection count saturates at 2: only none / one / many matters.
  logic [1:0] row_hits;
  logic [1:0] col_sel;
  logic [1:0] base_cnt;
  logic [3:0] base_code;
  logic [2:0] hit_sum;
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;

  always_comb begin
    row_hits  = {1'b0, col_sync_reg[0]} + {1'b0, col_sync_reg[1]} + {1'b0, col_sync_reg[2]};
    col_sel   = col_sync_reg[0] ? 2'd0 : (col_sync_reg[1] ? 2'd1 : 2'd2);
    base_cnt  = (row_idx_reg == 2'd0) ? 2'd0 : frame_cnt_reg;
    base_code = (row_idx_reg == 2'd0) ? 4'd0 : frame_code_reg;
    hit_sum   = {1'b0, base_cnt} + {1'b0, row_hits};
    acc_cnt   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    acc_code  = (row_hits == 2'd1) ? key_code(row_idx_reg, col_sel) : base_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg  <= 2'd0;
      frame_code_reg <= 4'd0;
    end else if (sample) begin
      frame_cnt_reg  <= acc_cnt;
      frame_code_reg <= acc_code;
    end
  end

  logic frame_none, frame_single, accept;
  logic [3:0] match_inc, rel_inc;
  assign frame_none   = (acc_cnt == 2'd0);
  assign frame_single = (acc_cnt == 2'd1);
  assign match_inc    = match_cnt_reg + 4'd1;
  assign rel_inc      = rel_cnt_reg + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= SCAN;
      match_cnt_reg <= 4'd0;
      rel_cnt_reg   <= 4'd0;
      cand_reg      <= 4'd0;
    end else begin
      state_reg     <= state_next;
      match_cnt_reg <= match_next;
      rel_cnt_reg   <= rel_next;
      cand_reg      <= cand_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    match_next = match_cnt_reg;
    rel_next   = rel_cnt_reg;
    cand_next  = cand_reg;
    accept     = 1'b0;
    if (frame_end) begin
      case (state_reg)
        SCAN: if (frame_single) begin
          cand_next  = acc_code;
          match_next = 4'd1;
          if (DB_TARGET == 4'd1) begin
            accept     = 1'b1;
            state_next = HELD;
          end else begin
            state_next = PRESS_DB;
          end
        end
        PRESS_DB: if (frame_single) begin
          if (acc_code == cand_reg) begin
            match_next = match_inc;
            if (match_inc == DB_TARGET) begin
              accept     = 1'b1;
              state_next = HELD;
            end
          end else begin
            cand_next  = acc_code;
            match_next = 4'd1;
          end
        end else begin
          match_next = 4'd0;
          state_next = SCAN;
        end
        HELD: if (frame_none) begin
          rel_next   = 4'd1;
          state_next = (DB_TARGET == 4'd1) ? SCAN : RELEASE_DB;
        end
        RELEASE_DB: if (frame_none) begin
          rel_next = rel_inc;
          if (rel_inc == DB_TARGET) state_next = SCAN;
        end else begin
          rel_next   = 4'd0;
          state_next = HELD;
        end
        default: state_next = SCAN;
      endcase
    end
  end

  // An accept while an unacknowledged key is pending drops the new key.
  always_comb begin
    key_value_next   = key_value_reg;
    key_ready_next   = key_ready_reg;
    key_overrun_next = 1'b0;
    if (accept) begin
      if (!key_ready_reg || key_ack) begin
        key_value_next = acc_code;
        key_ready_next = 1'b1;
      end else begin
        key_overrun_next = 1'b1;
      end
    end else if (key_ready_reg && key_ack) begin
      key_ready_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_value_reg   <= 4'd0;
      key_ready_reg   <= 1'b0;
      key_overrun_reg <= 1'b0;
    end else begin
      key_value_reg   <= key_value_next;
      key_ready_reg   <= key_ready_next;
      key_overrun_reg <= key_overrun_next;
    end
  end

  assign key_value   = key_value_reg;
  assign key_ready   = key_ready_reg;
  assign key_overrun = key_overrun_reg;

endmodule
